// File: rtl/world_fade_pkg.sv
// world_fade_pkg
// Shared constants for the world-transition fader: FSM state encodings,
// the full-brightness level and the one-hot map-enable decode table.
// No ports; imported by world_fade.
package world_fade_pkg;

    // FSM state encodings (also visible on world_fade.state_dbg)
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FADE_OUT = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;
    localparam logic [1:0] ST_FADE_IN  = 2'd3;

    // Brightness level meaning "fully lit"
    localparam logic [3:0] BRIGHT_MAX = 4'd15;

    // One-hot map enable codes
    localparam logic [3:0] MAP0_OH = 4'b0001;
    localparam logic [3:0] MAP1_OH = 4'b0010;
    localparam logic [3:0] MAP2_OH = 4'b0100;
    localparam logic [3:0] MAP3_OH = 4'b1000;

    // Returns {valid, index}. Anything other than exactly one set bit
    // (including 0000) is reported invalid.
    function automatic logic [2:0] onehot_decode(input logic [3:0] en);
        logic [2:0] res;
        case (en)
            MAP0_OH: res = {1'b1, 2'd0};
            MAP1_OH: res = {1'b1, 2'd1};
            MAP2_OH: res = {1'b1, 2'd2};
            MAP3_OH: res = {1'b1, 2'd3};
            default: res = {1'b0, 2'd0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/world_fade_timer.sv
// fade_timer
// Counts frame_tick pulses and pulses done on the length-th tick, then
// restarts from zero. clear holds the count at zero.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   clear  in  hold counter at zero (also suppresses done)
//   length in  ticks per done pulse (1..15)
//   tick   in  one-cycle frame pulse
//   done   out combinational pulse, high in the cycle of the length-th tick
module fade_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [3:0] length,
    input  logic       tick,
    output logic       done
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // done is combinational so the parent can act on the same edge
    // that consumes the final tick.
    assign done = tick && !clear && ((count_q + 4'd1) == length);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 4'd0;
        end else if (tick) begin
            if (done) begin
                count_d = 4'd0;
            end else begin
                count_d = count_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/world_fade.sv
// world_fade
// Fades the display to black, swaps the displayed map, and fades back in
// whenever the world-select stage requests a different map.
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous active-low reset
//   map_en     in  [3:0] one-hot map request (non-one-hot values ignored)
//   frame_tick in  one-cycle pulse per video frame
//   map_sel    out [1:0] index of the displayed map
//   brightness out [3:0] 15 = full, 0 = black
//   busy       out high for the whole transition
//   freeze     out high during FADE_OUT and HOLD (player input ignored)
//   state_dbg  out [1:0] current FSM state
// Handshake: map_en is a level request sampled every cycle; there is no
// ready. A request is accepted only in IDLE (start a transition), in
// FADE_OUT (retarget) or HOLD (retarget and swap immediately); during
// FADE_IN it is not looked at, so a held request is seen on the first
// IDLE cycle.
module world_fade
    import world_fade_pkg::*;
#(
    parameter int unsigned FADE_STEP_FRAMES = 2,
    parameter int unsigned HOLD_FRAMES      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] map_en,
    input  logic       frame_tick,
    output logic [1:0] map_sel,
    output logic [3:0] brightness,
    output logic       busy,
    output logic       freeze,
    output logic [1:0] state_dbg
);

    localparam logic [3:0] STEP_LEN = 4'(FADE_STEP_FRAMES);
    localparam logic [3:0] HOLD_LEN = 4'(HOLD_FRAMES);

    logic [1:0] state_q,  state_d;
    logic [1:0] target_q, target_d;
    logic [1:0] map_sel_q, map_sel_d;
    logic [3:0] bright_q, bright_d;
    logic       busy_q,   busy_d;
    logic       freeze_q, freeze_d;

    logic [2:0] en_dec;
    logic       en_valid;
    logic [1:0] en_idx;
    logic       timer_clear;
    logic [3:0] timer_len;
    logic       step_done;

    assign en_dec   = onehot_decode(map_en);
    assign en_valid = en_dec[2];
    assign en_idx   = en_dec[1:0];

    // Every state change happens on a done pulse (which self-clears the
    // counter) or out of IDLE (where the counter is held clear), so the
    // frame count always restarts at zero in a new state.
    assign timer_clear = (state_q == ST_IDLE);
    assign timer_len   = (state_q == ST_HOLD) ? HOLD_LEN : STEP_LEN;

    fade_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .length (timer_len),
        .tick   (frame_tick),
        .done   (step_done)
    );

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        map_sel_d = map_sel_q;
        bright_d  = bright_q;
        busy_d    = busy_q;
        freeze_d  = freeze_q;

        case (state_q)
            ST_IDLE: begin
                if (en_valid && (en_idx != map_sel_q)) begin
                    target_d = en_idx;
                    state_d  = ST_FADE_OUT;
                    busy_d   = 1'b1;
                    freeze_d = 1'b1;
                end
            end

            ST_FADE_OUT: begin
                // Last request wins; the fade itself keeps going.
                if (en_valid) begin
                    target_d = en_idx;
                end
                if (step_done) begin
                    if (bright_q <= 4'd1) begin
                        bright_d  = 4'd0;
                        state_d   = ST_HOLD;
                        // target_d so a request on this very edge is honoured
                        map_sel_d = target_d;
                    end else begin
                        bright_d = bright_q - 4'd1;
                    end
                end
            end

            ST_HOLD: begin
                // Screen is black, so a late retarget can swap at once.
                if (en_valid) begin
                    target_d  = en_idx;
                    map_sel_d = en_idx;
                end
                if (step_done) begin
                    state_d  = ST_FADE_IN;
                    freeze_d = 1'b0;
                end
            end

            ST_FADE_IN: begin
                if (step_done) begin
                    if (bright_q >= (BRIGHT_MAX - 4'd1)) begin
                        bright_d = BRIGHT_MAX;
                        state_d  = ST_IDLE;
                        busy_d   = 1'b0;
                    end else begin
                        bright_d = bright_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            target_q  <= 2'd0;
            map_sel_q <= 2'd0;
            bright_q  <= BRIGHT_MAX;
            busy_q    <= 1'b0;
            freeze_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            map_sel_q <= map_sel_d;
            bright_q  <= bright_d;
            busy_q    <= busy_d;
            freeze_q  <= freeze_d;
        end
    end

    assign map_sel    = map_sel_q;
    assign brightness = bright_q;
    assign busy       = busy_q;
    assign freeze     = freeze_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_world_fade.sv
// tb_world_fade
// Randomised bench for world_fade. The reference model tracks a
// transition as "frame ticks elapsed since it started" and derives the
// expected outputs from that count with plain arithmetic. Expected output
// words {busy, freeze, map_sel, brightness} are queued by the driver and
// compared on the following falling edge by the monitor.
module tb_world_fade;

    localparam int S        = 2;
    localparam int H        = 4;
    localparam int OUT_END  = 15 * S;
    localparam int HOLD_END = OUT_END + H;
    localparam int IN_END   = HOLD_END + 15 * S;

    logic       clk;
    logic       reset;
    logic [3:0] map_en;
    logic       frame_tick;
    logic [1:0] map_sel;
    logic [3:0] brightness;
    logic       busy;
    logic       freeze;
    logic [1:0] state_dbg;

    int checks;
    int errors;

    logic [7:0] exp_q[$];

    // reference model
    bit       m_busy;
    int       m_n;
    int       m_map;
    int       m_tgt;

    world_fade #(
        .FADE_STEP_FRAMES (S),
        .HOLD_FRAMES      (H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .map_en     (map_en),
        .frame_tick (frame_tick),
        .map_sel    (map_sel),
        .brightness (brightness),
        .busy       (busy),
        .freeze     (freeze),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_busy = 1'b0;
        m_n    = 0;
        m_map  = 0;
        m_tgt  = 0;
    endtask

    task automatic model_step(input logic [3:0] men, input logic tk);
        bit valid;
        int idx;
        valid = ($countones(men) == 1);
        idx = 0;
        for (int i = 0; i < 4; i++) if (men[i]) idx = i;
        if (!m_busy) begin
            if (valid && idx != m_map) begin
                m_busy = 1'b1;
                m_n    = 0;
                m_tgt  = idx;
            end
        end else begin
            if (valid && m_n < OUT_END) m_tgt = idx;
            if (valid && m_n >= OUT_END && m_n < HOLD_END) begin
                m_tgt = idx;
                m_map = idx;
            end
            if (tk) begin
                m_n++;
                if (m_n == OUT_END) m_map = m_tgt;
                if (m_n == IN_END) m_busy = 1'b0;
            end
        end
    endtask

    function automatic logic [7:0] model_out();
        int b;
        bit fr;
        if (!m_busy) return {1'b0, 1'b0, 2'(m_map), 4'd15};
        if (m_n < OUT_END) begin
            b = 15 - m_n / S;
            fr = 1'b1;
        end else if (m_n < HOLD_END) begin
            b = 0;
            fr = 1'b1;
        end else begin
            b = (m_n - HOLD_END) / S;
            fr = 1'b0;
        end
        return {1'b1, fr, 2'(m_map), 4'(b)};
    endfunction

    // ---------------- driver ----------------
    // Entered and left at posedge+1.
    task automatic drive(input logic [3:0] men, input logic tk);
        logic [7:0] e;
        map_en     = men;
        frame_tick = tk;
        model_step(men, tk);
        e = model_out();
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    function automatic logic rnd_tick();
        return ($urandom_range(0, 2) == 0);
    endfunction

    task automatic run_until_n(input int target, input logic [3:0] men);
        int guard;
        guard = 0;
        while (m_busy && m_n < target && guard < 2000) begin
            drive(men, rnd_tick());
            guard++;
        end
        if (guard >= 2000) begin
            checks++;
            errors++;
            $display("FAIL run_until_n: cycle budget exhausted, n=%0d want %0d", m_n, target);
        end
    endtask

    task automatic run_until_idle(input logic [3:0] men);
        int guard;
        guard = 0;
        while (m_busy && guard < 2000) begin
            drive(men, rnd_tick());
            guard++;
        end
        if (guard >= 2000) begin
            checks++;
            errors++;
            $display("FAIL run_until_idle: cycle budget exhausted, n=%0d", m_n);
        end
    endtask

    task automatic do_async_reset(input string name);
        logic [7:0] got;
        map_en     = 4'b0000;
        frame_tick = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        got = {busy, freeze, map_sel, brightness};
        checks++;
        if (got !== model_out()) begin
            errors++;
            $display("FAIL %s outputs: got %h expected %h", name, got, model_out());
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL %s state: got %0d expected 0", name, state_dbg);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [7:0] e;
        logic [7:0] got;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {busy, freeze, map_sel, brightness};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL cycle_out t=%0t: got busy=%b freeze=%b map=%0d bright=%0d expected busy=%b freeze=%b map=%0d bright=%0d",
                         $time, got[7], got[6], got[5:4], got[3:0], e[7], e[6], e[5:4], e[3:0]);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] men;
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        map_en     = 4'b0000;
        frame_tick = 1'b0;
        model_reset();

        do_async_reset("power_on_reset");

        // Request for the already-displayed map 0: nothing happens.
        for (int i = 0; i < 100; i++) drive(4'b0001, 1'b1);

        // Invalid encodings in IDLE: nothing happens.
        for (int i = 0; i < 10; i++) drive(4'b0110, 1'b1);
        for (int i = 0; i < 10; i++) drive(4'b0000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            men = 4'($urandom_range(0, 15));
            if ($countones(men) == 1) men = 4'b1111;
            drive(men, rnd_tick());
        end

        // Full transition to map 1, ticks every cycle from the start.
        drive(4'b0010, 1'b1);
        while (m_busy) drive(4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) drive(4'b0000, 1'b1);

        // Retarget during FADE_OUT at tick 10: single fade ending on map 3.
        drive(4'b0100, 1'b0);
        run_until_n(10, 4'b0000);
        drive(4'b1000, rnd_tick());
        run_until_n(OUT_END - 1, 4'b0000);
        drive(4'b0000, 1'b0);
        run_until_idle(4'b0000);
        drive(4'b0000, 1'b0);

        // Request held through FADE_IN: second transition right after IDLE.
        drive(4'b0001, 1'b0);
        run_until_n(HOLD_END, 4'b0000);
        run_until_idle(4'b1000);
        drive(4'b1000, 1'b0);
        drive(4'b0000, 1'b0);
        run_until_idle(4'b0000);

        // Retarget during HOLD, then reset while holding on map 2.
        drive(4'b0010, 1'b0);
        run_until_n(OUT_END + 1, 4'b0000);
        drive(4'b0100, 1'b0);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b0);
        do_async_reset("reset_in_hold");

        // After reset, map 0 request must not start a transition.
        for (int i = 0; i < 30; i++) drive(4'b0001, rnd_tick());

        // Reset in the middle of FADE_OUT and FADE_IN.
        drive(4'b1000, 1'b0);
        run_until_n(7, 4'b0000);
        do_async_reset("reset_in_fade_out");
        drive(4'b0100, 1'b0);
        run_until_n(HOLD_END + 5, 4'b0000);
        do_async_reset("reset_in_fade_in");

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 9))
                0: men = 4'($urandom_range(0, 15));
                1: men = 4'b0001 << $urandom_range(0, 3);
                default: men = 4'b0000;
            endcase
            drive(men, rnd_tick());
        end
        run_until_idle(4'b0000);
        drive(4'b0000, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
